// File: rtl/xtal_startup_ctrl.sv
// xtal_startup_ctrl: crystal pad enable, startup wait, edge-count qualification and loss watch with bounded retries
module xtal_startup_ctrl #(
  parameter int STARTUP_CYC = 1024,
  parameter int WIN_CYC     = 64,
  parameter int MIN_EDGES   = 4,
  parameter int MAX_EDGES   = 28,
  parameter int LOSS_CYC    = 16,
  parameter int MAX_RETRY   = 3,
  parameter int CW          = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       xtal_req,
  input  logic       fault_clr,
  input  logic       xtal_clk,
  output logic       xtal_en,
  output logic       clk_sel,
  output logic       xtal_ok,
  output logic       xtal_fault,
  output logic [1:0] retry_cnt,
  output logic [2:0] state
);
  typedef enum logic [2:0] {OFF = 3'd0, START = 3'd1, CHECK = 3'd2, RUN = 3'd3, FAIL = 3'd4} st_t;
  localparam int EW = $clog2(WIN_CYC + 2);
  localparam logic [CW-1:0] T_START = CW'(STARTUP_CYC - 1);
  localparam logic [CW-1:0] T_WIN   = CW'(WIN_CYC - 1);
  localparam logic [CW-1:0] T_LOSS  = CW'(LOSS_CYC - 1);
  localparam logic [EW-1:0] E_MIN   = EW'(MIN_EDGES);
  localparam logic [EW-1:0] E_MAX   = EW'(MAX_EDGES);
  localparam logic [1:0]    R_MAX   = 2'(MAX_RETRY);
  st_t st, nst;
  logic [CW-1:0] tmr, ntmr;
  logic [EW-1:0] ecnt, necnt, nedge;
  logic [1:0] nretry;
  logic nfault, s1, s2, s3, edg, tz;
  assign edg = s2 & ~s3;
  assign tz = tmr == '0;
  assign nedge = (ecnt == '1) ? ecnt : ecnt + EW'(edg);
  assign state = st;
  always_comb begin
    nst = st;
    ntmr = tmr;
    necnt = ecnt;
    nretry = fault_clr ? 2'd0 : retry_cnt;
    nfault = xtal_fault & ~fault_clr;
    if (!xtal_req) begin
      nst = OFF;
      nretry = 2'd0;
    end else begin
      case (st)
        OFF: if (!nfault) begin
          nst = START;
          ntmr = T_START;
        end
        START: if (tz) begin
          nst = CHECK;
          ntmr = T_WIN;
          necnt = '0;
        end else ntmr = tmr - CW'(1);
        CHECK: begin
          necnt = nedge;
          if (tz) begin
            nst = (nedge >= E_MIN && nedge <= E_MAX) ? RUN : FAIL;
            ntmr = T_LOSS;
          end else ntmr = tmr - CW'(1);
        end
        RUN: if (edg) ntmr = T_LOSS;
        else if (tz) begin
          nst = FAIL;
          ntmr = T_LOSS;
        end else ntmr = tmr - CW'(1);
        FAIL: if (!tz) ntmr = tmr - CW'(1);
        else if (retry_cnt < R_MAX) begin
          nretry = retry_cnt + 2'd1;
          nst = START;
          ntmr = T_START;
        end else begin
          nfault = 1'b1;
          nst = OFF;
        end
        default: nst = OFF;
      endcase
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      {s3, s2, s1} <= '0;
      st <= OFF;
      tmr <= '0;
      ecnt <= '0;
      retry_cnt <= '0;
      xtal_fault <= 1'b0;
      xtal_en <= 1'b0;
      clk_sel <= 1'b0;
      xtal_ok <= 1'b0;
    end else begin
      {s3, s2, s1} <= {s2, s1, xtal_clk};
      st <= nst;
      tmr <= ntmr;
      ecnt <= necnt;
      retry_cnt <= nretry;
      xtal_fault <= nfault;
      xtal_en <= nst inside {START, CHECK, RUN};
      clk_sel <= nst == RUN;
      xtal_ok <= nst == RUN;
    end
  end
endmodule

// File: tb/tb_xtal_startup_ctrl.sv
// tb_xtal_startup_ctrl: directed sequences, boundary table and random run against a phase/elapsed-time model
module tb_xtal_startup_ctrl;
  localparam int STARTUP = 1024, WIN = 64, MINE = 4, MAXE = 28, LOSS = 16, MAXR = 3;
  localparam int S_OFF = 0, S_START = 1, S_CHECK = 2, S_RUN = 3, S_FAIL = 4;
  logic clk = 1'b0, resetn, xtal_req, fault_clr, xtal_clk;
  logic xtal_en, clk_sel, xtal_ok, xtal_fault;
  logic [1:0] retry_cnt;
  logic [2:0] state;
  int passed = 0, total = 0;
  int m_st, m_el, m_edges, m_since, m_retry;
  logic m_fault;
  logic [2:0] hist;
  int xhalf, xcnt;
  logic xv;
  typedef struct {int n; int d; int exp_st;} vec_t;
  vec_t tbl[6];
  int n, cyc, len;
  logic x, r, c;

  always #5 clk = ~clk;

  xtal_startup_ctrl dut (
    .clk(clk), .resetn(resetn), .xtal_req(xtal_req), .fault_clr(fault_clr), .xtal_clk(xtal_clk),
    .xtal_en(xtal_en), .clk_sel(clk_sel), .xtal_ok(xtal_ok), .xtal_fault(xtal_fault),
    .retry_cnt(retry_cnt), .state(state)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic model_reset();
    m_st = S_OFF; m_el = 0; m_edges = 0; m_since = 0; m_retry = 0; m_fault = 1'b0; hist = '0;
  endtask

  // hist[i] holds the xtal sample taken i+1 edges ago; a rise seen two samples back is an edge now
  task automatic model_step(input logic rq, input logic cl, input logic xs);
    logic e, nf;
    int nr;
    e = hist[1] & ~hist[2];
    hist = {hist[1:0], xs};
    nf = m_fault & ~cl;
    nr = cl ? 0 : m_retry;
    if (!rq) begin
      m_st = S_OFF;
      nr = 0;
    end else begin
      case (m_st)
        S_OFF: if (!nf) begin m_st = S_START; m_el = 0; end
        S_START: begin
          m_el++;
          if (m_el == STARTUP) begin m_st = S_CHECK; m_el = 0; m_edges = 0; end
        end
        S_CHECK: begin
          m_edges += int'(e);
          m_el++;
          if (m_el == WIN) begin
            m_st = (m_edges >= MINE && m_edges <= MAXE) ? S_RUN : S_FAIL;
            m_el = 0;
            m_since = 0;
          end
        end
        S_RUN: begin
          m_since = e ? 0 : m_since + 1;
          if (m_since == LOSS) begin m_st = S_FAIL; m_el = 0; end
        end
        S_FAIL: begin
          m_el++;
          if (m_el == LOSS) begin
            if (m_retry < MAXR) begin nr = m_retry + 1; m_st = S_START; m_el = 0; end
            else begin nf = 1'b1; m_st = S_OFF; end
          end
        end
        default: m_st = S_OFF;
      endcase
    end
    m_fault = nf;
    m_retry = nr;
  endtask

  task automatic tick(input logic rq, input logic cl, input logic xs);
    logic [8:0] exp, act;
    xtal_req = rq; fault_clr = cl; xtal_clk = xs;
    @(posedge clk);
    model_step(rq, cl, xs);
    @(negedge clk);
    exp = {3'(m_st), (m_st >= S_START && m_st <= S_RUN), m_st == S_RUN, m_st == S_RUN, m_fault, 2'(m_retry)};
    act = {state, xtal_en, clk_sel, xtal_ok, xtal_fault, retry_cnt};
    total++;
    if (act === exp) passed++;
    else $display("FAIL model t=%0t {state,en,sel,ok,fault,retry} got %b expected %b", $time, act, exp);
  endtask

  task automatic tickg(input logic rq, input logic cl);
    if (xhalf == 0) xv = 1'b0;
    else begin
      xcnt++;
      if (xcnt >= xhalf) begin xcnt = 0; xv = ~xv; end
    end
    tick(rq, cl, xv);
  endtask

  task automatic do_reset();
    resetn = 1'b0; xtal_req = 1'b0; fault_clr = 1'b0; xtal_clk = 1'b0; xv = 1'b0; xcnt = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic wait_st(input int s, input int bound, input logic rq, output int cnt);
    cnt = 0;
    while (int'(state) != s && cnt < bound) begin tickg(rq, 1'b0); cnt++; end
    chk($sformatf("reach state %0d", s), int'(state), s);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    xhalf = 0;
    do_reset();
    chk("reset outputs", int'({state, xtal_en, clk_sel, xtal_ok, xtal_fault, retry_cnt}), 0);

    // normal start with period-8 crystal
    xhalf = 4;
    tickg(1, 0);
    chk("t1 en after req", int'(xtal_en), 1);
    chk("t1 state START", int'(state), S_START);
    wait_st(S_CHECK, 1100, 1, n);
    chk("t1 cycles to CHECK", n, 1024);
    wait_st(S_RUN, 100, 1, n);
    chk("t1 cycles in CHECK", n, 64);
    chk("t1 clk_sel", int'(clk_sel), 1);
    chk("t1 xtal_ok", int'(xtal_ok), 1);
    chk("t1 retry", int'(retry_cnt), 0);

    // loss in RUN
    xhalf = 0;
    wait_st(S_FAIL, LOSS + 4, 1, n);
    chk("t4 loss latency ok", int'(n <= LOSS + 4), 1);
    chk("t4 clk_sel low", int'(clk_sel), 0);
    wait_st(S_START, LOSS + 2, 1, n);
    chk("t4 retry after loss", int'(retry_cnt), 1);

    // request drop mid-START and mid-RUN
    repeat (100) tickg(1, 0);
    tickg(0, 0);
    chk("t5 drop START state", int'(state), S_OFF);
    chk("t5 drop START en", int'(xtal_en), 0);
    chk("t5 drop START retry", int'(retry_cnt), 0);
    xhalf = 4;
    wait_st(S_RUN, 1200, 1, n);
    repeat (5) tickg(1, 0);
    tickg(0, 0);
    chk("t5 drop RUN state", int'(state), S_OFF);
    chk("t5 drop RUN clk_sel", int'(clk_sel), 0);

    // too fast crystal
    do_reset();
    xhalf = 1;
    wait_st(S_CHECK, 1100, 1, n);
    wait_st(S_FAIL, 100, 1, n);
    chk("t3 fail at window end", n, 64);
    wait_st(S_START, 40, 1, n);
    chk("t3 cool-down length", n, 16);
    chk("t3 retry", int'(retry_cnt), 1);

    // dead crystal, sticky fault, fault_clr restart
    do_reset();
    xhalf = 0;
    n = 0;
    while (!xtal_fault && n < 6000) begin tickg(1, 0); n++; end
    chk("t2 fault set", int'(xtal_fault), 1);
    chk("t2 state OFF", int'(state), S_OFF);
    chk("t2 retry", int'(retry_cnt), 3);
    chk("t2 en low", int'(xtal_en), 0);
    repeat (5) tickg(1, 0);
    chk("t2 stays OFF", int'(state), S_OFF);
    tickg(1, 1);
    chk("t2 clr restarts", int'(state), S_START);
    chk("t2 clr fault", int'(xtal_fault), 0);

    // fault_clr in the same cycle the fault is set
    n = 0;
    while (!(int'(state) == S_FAIL && retry_cnt == 2'd3) && n < 6000) begin tickg(1, 0); n++; end
    chk("t6 reach final FAIL", int'(state), S_FAIL);
    repeat (15) tickg(1, 0);
    tickg(1, 1);
    chk("t6 set beats clr", int'(xtal_fault), 1);
    chk("t6 state OFF", int'(state), S_OFF);

    // async reset mid-CHECK
    do_reset();
    xhalf = 4;
    wait_st(S_CHECK, 1100, 1, n);
    repeat (10) tickg(1, 0);
    #2 resetn = 1'b0;
    #1 chk("async reset outputs", int'({state, xtal_en, clk_sel, xtal_ok, xtal_fault, retry_cnt}), 0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;

    // edge-count boundaries: n pulses starting d cycles into the window
    tbl[0] = '{4, 0, S_RUN};
    tbl[1] = '{3, 0, S_FAIL};
    tbl[2] = '{28, 0, S_RUN};
    tbl[3] = '{29, 0, S_FAIL};
    tbl[4] = '{4, 55, S_RUN};
    tbl[5] = '{4, 56, S_FAIL};
    for (int i = 0; i < 6; i++) begin
      do_reset();
      xhalf = 0;
      wait_st(S_CHECK, 1100, 1, n);
      for (int k = 0; k < WIN; k++) begin
        x = (k >= tbl[i].d && k < tbl[i].d + 2 * tbl[i].n && ((k - tbl[i].d) % 2) == 0);
        tick(1, 0, x);
      end
      chk($sformatf("edges n=%0d d=%0d", tbl[i].n, tbl[i].d), int'(state), tbl[i].exp_st);
    end

    // random segments
    do_reset();
    cyc = 0;
    while (cyc < 16000) begin
      len = $urandom_range(20, 2500);
      xhalf = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
      r = ($urandom_range(0, 9) != 0);
      for (int k = 0; k < len; k++) begin
        c = ($urandom_range(0, 299) == 0);
        tickg(r, c);
        cyc++;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
